flash_emulator: RTL and testbench
=================================

FLASH_EMULATOR -- requirements
Module: flash_emulator

Interface
REQ-001 Parameter ADDR_SIZE, default 10, word-address width; array depth 2^ADDR_SIZE x 16 bits.
REQ-002 Parameter BLOCK_BITS, default 4, log2 of words per erase block (BLOCK_BITS < ADDR_SIZE).
REQ-003 Parameter PROG_CYCLES, default 8, clocks of busy time per word program (>= 1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flash_addr  input  ADDR_SIZE+1  byte address; word address = flash_addr[ADDR_SIZE:1]; bit 0 ignored.
REQ-007 flash_data  inout  16  data bus; driven only per REQ-010, else high-impedance.
REQ-008 flash_ctl  input  8  {byte, ce_n, ce1, ce2, oe_n, rp_n, vpen, we_n}, bit 7 down to bit 0.
REQ-009 dev_busy  output  1  high while a program or erase is in progress.

Function
REQ-010 Chip selected when ce_n=0, ce1=0, ce2=0; flash_data driven when selected AND oe_n=0 AND we_n=1, combinationally from the read register (REQ-013).
REQ-011 Command write: we_n sampled each clk; while selected and we_n=0, word address and flash_data captured each cycle; a write event fires in the first cycle we_n samples 1 after sampling 0, using the last captured values.
REQ-012 Modes: READ_ARRAY, READ_STATUS, PROG_SETUP, ERASE_SETUP, PROG_BUSY, ERASE_BUSY.
REQ-013 Read register updated every clk: READ_ARRAY -> mem[word address]; all other modes -> {8'h00, SR}; one-clock latency from address/mode change.
REQ-014 SR bits: SR7 ready (0 while busy), SR5 erase error, SR4 program error, SR3 vpen-low error; other bits 0.
REQ-015 Write-event decode on data[7:0] in READ_ARRAY/READ_STATUS: 0xFF -> READ_ARRAY; 0x70 -> READ_STATUS; 0x50 -> clear SR5/SR4/SR3, mode unchanged; 0x40 or 0x10 -> PROG_SETUP; 0x20 -> ERASE_SETUP; other -> ignored.
REQ-016 PROG_SETUP write event: latch address and data; vpen=1 -> PROG_BUSY, counter=PROG_CYCLES; vpen=0 -> set SR4, SR3, no write; either way read mode becomes status.
REQ-017 PROG_BUSY: counter decrements per clk; at 0, mem[addr] <= mem[addr] & data (bits only cleared), SR7=1, mode READ_STATUS.
REQ-018 ERASE_SETUP write event: 0xD0 and vpen=1 -> ERASE_BUSY on block of latched address; 0xD0 and vpen=0 -> set SR5, SR3; other data -> set SR5, SR4; non-busy outcomes -> READ_STATUS.
REQ-019 ERASE_BUSY: one word of block written 16'hFFFF per clk, ascending from block base; after last word SR7=1, mode READ_STATUS; total busy 2^BLOCK_BITS clks.
REQ-020 During PROG_BUSY/ERASE_BUSY all write events ignored; reads return status.
REQ-021 dev_busy = 1 exactly in PROG_BUSY/ERASE_BUSY; SR7 = ~dev_busy.
REQ-022 Writes to byte bit ignored; word mode only.
REQ-023 rp_n=0 acts as reset (REQ-025) every cycle it is sampled low.

Reset
REQ-024 Array contents power up 16'hFFFF; not affected by rst or rp_n.
REQ-025 On rst=1 (or rp_n=0): mode READ_ARRAY, SR=8'h80, dev_busy=0, counters 0, captured we_n treated as 1 (no write event next cycle); in-progress operation aborted, words already written retained.

Verification
REQ-026 Power-up read addr 0x004 (byte 0x008), oe_n low 2 clks -> flash_data=16'hFFFF; oe_n high -> Z.
REQ-027 0x40 then 0x1234 at word 0x010 -> dev_busy high PROG_CYCLES clks, 0x70 read gives 0x0080 after; 0xFF, read word 0x010 -> 0x1234; program 0xFF00 again -> 0x1200.
REQ-028 0x20 then 0xD0 at word 0x013 -> words 0x010-0x01F read 0xFFFF, busy 16 clks, other blocks unchanged.
REQ-029 0x20 then 0x55 -> status 0x00B0, no erase; 0x50 -> status 0x0080.
REQ-030 Program with vpen=0 -> status 0x0098, array unchanged; command write during ERASE_BUSY ignored.
REQ-031 rst asserted mid-erase -> dev_busy 0 next clk, READ_ARRAY, partially erased words remain 0xFFFF, rest untouched.

Source files
------------

// File: rtl/flash_emulator.sv
// Word-wide parallel NOR flash model: command decoder, status register,
// timed word program and block erase over a 2^ADDR_SIZE x 16 array.
module flash_emulator #(
   parameter int ADDR_SIZE   = 10,
   parameter int BLOCK_BITS  = 4,
   parameter int PROG_CYCLES = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_SIZE:0] flash_addr,
   inout  wire  [15:0]        flash_data,
   input  logic [7:0]         flash_ctl,
   output logic               dev_busy
);

   localparam int CW = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

   typedef enum logic [2:0] {
      READ_ARRAY, READ_STATUS, PROG_SETUP, ERASE_SETUP, PROG_BUSY, ERASE_BUSY
   } mode_t;

   mode_t                 mode, mode_nxt;
   logic                  ce_n, ce1, ce2, oe_n, rp_n, vpen, we_n;
   logic                  sel, rst_all, wr_evt, we_low_q;
   logic [ADDR_SIZE-1:0]  word_addr, cap_addr, prog_addr, erase_ptr;
   logic [15:0]           cap_data, prog_data, rd_reg;
   logic [7:0]            cmd, status;
   logic [2:0]            sr_err;          // {SR5, SR4, SR3}
   logic [CW-1:0]         prog_cnt;
   logic                  prog_done, erase_done;
   logic                  unused_ok;

   // Stored inverted so the all-zero power-up state of the RAM reads as erased.
   logic [15:0]           mem_n [2**ADDR_SIZE];

   assign {ce_n, ce1, ce2, oe_n, rp_n, vpen, we_n} = flash_ctl[6:0];
   assign unused_ok  = ^{flash_ctl[7], flash_addr[0]};
   assign sel        = ~ce_n & ~ce1 & ~ce2;
   assign rst_all    = rst | ~rp_n;
   assign word_addr  = flash_addr[ADDR_SIZE:1];
   assign cmd        = cap_data[7:0];
   assign wr_evt     = we_low_q & we_n;
   assign prog_done  = (prog_cnt == '0);
   assign erase_done = (erase_ptr[BLOCK_BITS-1:0] == '1);
   assign flash_data = (sel & ~oe_n & we_n) ? rd_reg : 16'hzzzz;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst_all) we_low_q <= 1'b0;
      else         we_low_q <= sel & ~we_n;
   end

   always_ff @(posedge clk) begin
      if (sel && !we_n) begin
         cap_addr <= word_addr;
         cap_data <= flash_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_all) mode <= READ_ARRAY;
      else         mode <= mode_nxt;
   end

   // NOTE: mode_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      mode_nxt = mode;
      unique case (mode)
         READ_ARRAY, READ_STATUS:
            if (wr_evt) begin
               case (cmd)
                  8'hFF:        mode_nxt = READ_ARRAY;
                  8'h70:        mode_nxt = READ_STATUS;
                  8'h40, 8'h10: mode_nxt = PROG_SETUP;
                  8'h20:        mode_nxt = ERASE_SETUP;
                  default:      mode_nxt = mode;
               endcase
            end
         PROG_SETUP:  if (wr_evt) mode_nxt = vpen ? PROG_BUSY : READ_STATUS;
         ERASE_SETUP: if (wr_evt) mode_nxt = (cmd == 8'hD0 && vpen) ? ERASE_BUSY : READ_STATUS;
         PROG_BUSY:   if (prog_done) mode_nxt = READ_STATUS;
         ERASE_BUSY:  if (erase_done) mode_nxt = READ_STATUS;
         default:     mode_nxt = READ_ARRAY;
      endcase
   end

   always_comb begin
      dev_busy = (mode == PROG_BUSY) || (mode == ERASE_BUSY);
      status   = {~dev_busy, 1'b0, sr_err, 3'b000};
   end

   always_ff @(posedge clk) begin
      if (rst_all) begin
         sr_err    <= '0;
         prog_cnt  <= '0;
         erase_ptr <= '0;
      end else begin
         case (mode)
            READ_ARRAY, READ_STATUS:
               if (wr_evt && cmd == 8'h50) sr_err <= '0;
            PROG_SETUP:
               if (wr_evt) begin
                  prog_cnt <= CW'(PROG_CYCLES - 1);
                  if (!vpen) sr_err <= sr_err | 3'b011;
               end
            ERASE_SETUP:
               if (wr_evt) begin
                  if (cmd != 8'hD0) sr_err    <= sr_err | 3'b110;
                  else if (!vpen)   sr_err    <= sr_err | 3'b101;
                  else              erase_ptr <= {cap_addr[ADDR_SIZE-1:BLOCK_BITS], {BLOCK_BITS{1'b0}}};
               end
            PROG_BUSY:  if (!prog_done) prog_cnt <= prog_cnt - 1'b1;
            ERASE_BUSY: erase_ptr <= erase_ptr + 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mode == PROG_SETUP && wr_evt) begin
         prog_addr <= cap_addr;
         prog_data <= cap_data;
      end
   end

   // NOTE: the array and read register carry no reset; contents must survive
   // rst/rp_n, and only the write enables are gated so aborts stop mid-block.
   always_ff @(posedge clk) begin
      if (!rst_all) begin
         if (mode == PROG_BUSY && prog_done)
            mem_n[prog_addr] <= mem_n[prog_addr] | ~prog_data;
         else if (mode == ERASE_BUSY)
            mem_n[erase_ptr] <= '0;
      end
      rd_reg <= (mode == READ_ARRAY) ? ~mem_n[word_addr] : {8'h00, status};
   end

endmodule

// File: tb/tb_flash_emulator.sv
// Directed self-checking bench for flash_emulator: reads, program, erase,
// error status paths and reset/rp_n aborts.
module tb_flash_emulator;

   localparam int ADDR_SIZE   = 10;
   localparam int PROG_CYCLES = 8;
   localparam int BLOCK_WORDS = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [ADDR_SIZE:0]   flash_addr;
   wire  [15:0]          flash_data;
   logic [15:0]          data_drv;
   logic                 data_oe;
   logic                 byte_b, ce_n, ce1, ce2, oe_n, rp_n, vpen, we_n;
   logic                 dev_busy;
   int                   checks   = 0;
   int                   failures = 0;

   assign flash_data = data_oe ? data_drv : 16'hzzzz;

   flash_emulator #(.ADDR_SIZE(ADDR_SIZE), .BLOCK_BITS(4), .PROG_CYCLES(PROG_CYCLES)) dut (
      .clk        (clk),
      .rst        (rst),
      .flash_addr (flash_addr),
      .flash_data (flash_data),
      .flash_ctl  ({byte_b, ce_n, ce1, ce2, oe_n, rp_n, vpen, we_n}),
      .dev_busy   (dev_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic cmd_write(input logic [9:0] w, input logic [15:0] d);
      flash_addr = {w, 1'b0};
      data_drv   = d;
      data_oe    = 1'b1;
      ce_n       = 1'b0;
      we_n       = 1'b0;
      @(negedge clk);
      we_n       = 1'b1;
      data_oe    = 1'b0;
      @(negedge clk);
      ce_n       = 1'b1;
   endtask

   task automatic rd(input logic [9:0] w, output logic [15:0] v);
      flash_addr = {w, 1'b0};
      ce_n       = 1'b0;
      oe_n       = 1'b0;
      repeat (2) @(negedge clk);
      v          = flash_data;
      oe_n       = 1'b1;
      ce_n       = 1'b1;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (dev_busy && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic program_word(input logic [9:0] w, input logic [15:0] d);
      int n;
      cmd_write(w, 16'h0040);
      cmd_write(w, d);
      wait_idle(n);
      check($sformatf("prog_busy_%h", w), n, PROG_CYCLES);
   endtask

   initial begin
      logic [15:0] v;
      int          n;
      rst = 1'b1; flash_addr = '0; data_drv = '0; data_oe = 1'b0;
      byte_b = 1'b0; ce_n = 1'b1; ce1 = 1'b0; ce2 = 1'b0;
      oe_n = 1'b1; rp_n = 1'b1; vpen = 1'b1; we_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_busy", dev_busy, 0);

      // power-up contents and bus release
      rd(10'h004, v);            check("pwrup_004", v, 16'hFFFF);
      rd(10'h3FF, v);            check("pwrup_3ff", v, 16'hFFFF);
      ce_n = 1'b0; data_oe = 1'b1; data_drv = 16'h0000;
      @(negedge clk);
      check("hiz_when_oe_high", flash_data, 16'h0000);
      data_oe = 1'b0; ce_n = 1'b1;

      // word program, then bits-only-cleared reprogram
      program_word(10'h010, 16'h1234);
      rd(10'h000, v);            check("status_after_prog", v, 16'h0080);
      cmd_write(10'h000, 16'h00FF);
      rd(10'h010, v);            check("prog_010", v, 16'h1234);
      rd(10'h011, v);            check("neighbour_011", v, 16'hFFFF);
      program_word(10'h010, 16'hFF00);
      cmd_write(10'h000, 16'h00FF);
      rd(10'h010, v);            check("reprog_010", v, 16'h1200);
      program_word(10'h00F, 16'h0F0F);
      program_word(10'h025, 16'hABCD);

      // block erase of 0x010-0x01F with a command issued mid-erase
      cmd_write(10'h000, 16'h0020);
      cmd_write(10'h013, 16'h00D0);
      check("erase_busy_start", dev_busy, 1);
      rd(10'h000, v);            check("status_during_erase", v, 16'h0000);
      cmd_write(10'h000, 16'h00FF);
      wait_idle(n);
      check("erase_busy_clks", n + 4, BLOCK_WORDS);
      rd(10'h000, v);            check("status_after_erase", v, 16'h0080);
      cmd_write(10'h000, 16'h00FF);
      rd(10'h010, v);            check("erased_010", v, 16'hFFFF);
      rd(10'h01F, v);            check("erased_01f", v, 16'hFFFF);
      rd(10'h00F, v);            check("kept_00f", v, 16'h0F0F);
      rd(10'h025, v);            check("kept_025", v, 16'hABCD);

      // bad erase confirm, then clear status
      cmd_write(10'h000, 16'h0020);
      cmd_write(10'h025, 16'h0055);
      check("bad_confirm_busy", dev_busy, 0);
      rd(10'h000, v);            check("status_bad_confirm", v, 16'h00B0);
      cmd_write(10'h000, 16'h0050);
      rd(10'h000, v);            check("status_cleared", v, 16'h0080);

      // vpen low: program and erase both rejected
      vpen = 1'b0;
      cmd_write(10'h030, 16'h0040);
      cmd_write(10'h030, 16'h0000);
      check("vpen_prog_busy", dev_busy, 0);
      rd(10'h000, v);            check("status_vpen_prog", v, 16'h0098);
      cmd_write(10'h000, 16'h0050);
      cmd_write(10'h000, 16'h0020);
      cmd_write(10'h025, 16'h00D0);
      rd(10'h000, v);            check("status_vpen_erase", v, 16'h00A8);
      cmd_write(10'h000, 16'h0050);
      cmd_write(10'h000, 16'h00FF);
      vpen = 1'b1;
      rd(10'h030, v);            check("vpen_030_unchanged", v, 16'hFFFF);
      rd(10'h025, v);            check("vpen_025_unchanged", v, 16'hABCD);

      // rst in the middle of an erase of block 0x040-0x04F
      program_word(10'h040, 16'h1111);
      program_word(10'h04F, 16'h2222);
      cmd_write(10'h000, 16'h0020);
      cmd_write(10'h04A, 16'h00D0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_abort_busy", dev_busy, 0);
      rd(10'h040, v);            check("abort_erased_040", v, 16'hFFFF);
      rd(10'h04F, v);            check("abort_kept_04f", v, 16'h2222);

      // rp_n low aborts a program
      cmd_write(10'h060, 16'h0040);
      cmd_write(10'h060, 16'h0000);
      @(negedge clk);
      rp_n = 1'b0;
      @(negedge clk);
      rp_n = 1'b1;
      check("rpn_abort_busy", dev_busy, 0);
      rd(10'h060, v);            check("rpn_060_unchanged", v, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
